// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and the load/store unit.
// Arbitrates, sequences each access, aligns store lanes and extends load data.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic ls_legal(input logic we, input logic [2:0] len, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (len)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~lane[0];
      3'b010:  ok = (lane == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] ls_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] st_align(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = 32'd0;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ld_extract(input logic [2:0] len, input logic [1:0] lane,
                                             input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = rdata >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? rdata[31:16] : rdata[15:0];
    r       = 32'd0;
    case (len)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rdata;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_if_q, owner_if_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  lane_q, lane_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic if_win_s, ls_win_s, ls_illegal_s;
  logic unused_s;

  // Fetch pre-empts loads/stores only once the starve counter has reached the limit.
  assign if_win_s     = (state_q == ST_IDLE) & if_req & (~ls_req | (starve_q == LIMIT));
  assign ls_win_s     = (state_q == ST_IDLE) & ls_req & ~if_win_s;
  assign ls_illegal_s = ~ls_legal(ls_we, ls_len, ls_addr[1:0]);
  assign unused_s     = ^if_addr[1:0];

  // State, transaction and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= 4'd0;
      owner_if_q  <= 1'b0;
      len_q       <= 3'd0;
      lane_q      <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_if_q  <= owner_if_d;
      len_q       <= len_d;
      lane_q      <= lane_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (if_win_s) begin
          state_d = ST_BUSY;
        end else if (ls_win_s) begin
          state_d = ls_illegal_s ? ST_ERR : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: state_d = mem_ready ? ST_RESP : ST_BUSY;
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction capture at grant, starve tracking and response data.
  always_comb begin
    starve_d    = starve_q;
    owner_if_d  = owner_if_q;
    len_d       = len_q;
    lane_d      = lane_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if (if_win_s) begin
      starve_d    = 4'd0;
      owner_if_d  = 1'b1;
      len_d       = 3'b010;
      lane_d      = 2'b00;
      mem_we_d    = 1'b0;
      mem_addr_d  = {if_addr[31:2], 2'b00};
      mem_be_d    = 4'b1111;
      mem_wdata_d = 32'd0;
    end else if (ls_win_s) begin
      if (if_req) begin
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
      end else begin
        starve_d = 4'd0;
      end
      owner_if_d  = 1'b0;
      len_d       = ls_len;
      lane_d      = ls_addr[1:0];
      mem_we_d    = ls_we;
      mem_addr_d  = {ls_addr[31:2], 2'b00};
      mem_be_d    = ls_be(ls_len[1:0], ls_addr[1:0]);
      mem_wdata_d = ls_we ? st_align(ls_len[1:0], ls_wdata) : 32'd0;
    end else begin
      starve_d = starve_q;
    end
    // An error completion reports zero data, so clear it as the illegal request is taken.
    if ((state_q == ST_BUSY) && mem_ready) begin
      if (owner_if_q) begin
        if_rdata_d = mem_rdata;
      end else begin
        ls_rdata_d = mem_we_q ? 32'd0 : ld_extract(len_q, lane_q, mem_rdata);
      end
    end else if (ls_win_s && ls_illegal_s) begin
      ls_rdata_d = 32'd0;
    end else begin
      ls_rdata_d = ls_rdata_q;
    end
  end

  // Output decode from state; grants are suppressed while reset is asserted.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_req   = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    ls_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if_gnt = if_win_s & rst_n;
        ls_gnt = ls_win_s & rst_n;
      end
      ST_BUSY: mem_req = 1'b1;
      ST_RESP: begin
        if_rvalid = owner_if_q;
        ls_rvalid = ~owner_if_q;
      end
      ST_ERR: begin
        ls_rvalid = 1'b1;
        ls_err    = 1'b1;
      end
      default: begin
        if_gnt = 1'b0;
      end
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (STARVE_LIMIT=2 instance).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [2:0]  ls_len;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_ls(input vec_t v, input int idx);
    @(negedge clk);
    ls_req = 1'b1; ls_we = v.we; ls_len = v.len; ls_addr = v.addr; ls_wdata = v.wdata;
    mem_ready = 1'b1; mem_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_gnt", idx), {if_gnt, ls_gnt}, 64'b01);
    @(posedge clk); #1;
    ls_req = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_err", idx), {mem_req, ls_rvalid, ls_err}, 64'b011);
      chk($sformatf("v%0d_err_rdata", idx), ls_rdata, 64'd0);
    end else begin
      chk($sformatf("v%0d_memreq", idx), {mem_req, mem_we, mem_be}, {58'd0, 1'b1, v.we, v.be});
      chk($sformatf("v%0d_addr", idx), mem_addr, {32'd0, v.addr & 32'hFFFF_FFFC});
      if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata, {32'd0, v.mwdata});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid", idx), {mem_req, ls_rvalid, ls_err, if_rvalid}, 64'b0100);
      chk($sformatf("v%0d_rdata", idx), ls_rdata, {32'd0, v.exp});
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx), {ls_rvalid, ls_err}, 64'b00);
  endtask

  initial begin
    logic [1:0] order[6];
    logic [1:0] got;
    //         we    len     addr          wdata         rdata        err   be       mwdata        exp
    vecs[0]  = '{1'b0, 3'b000, 32'h1000_0002, 32'h0,        32'h1280_FF34, 1'b0, 4'b0100, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b100, 32'h1000_0002, 32'h0,        32'h1280_FF34, 1'b0, 4'b0100, 32'h0,        32'h0000_0080};
    vecs[2]  = '{1'b0, 3'b101, 32'h1000_0002, 32'h0,        32'h1280_FF34, 1'b0, 4'b1100, 32'h0,        32'h0000_1280};
    vecs[3]  = '{1'b0, 3'b001, 32'h1000_0000, 32'h0,        32'h1280_FF34, 1'b0, 4'b0011, 32'h0,        32'hFFFF_FF34};
    vecs[4]  = '{1'b0, 3'b010, 32'h2000_0008, 32'h0,        32'h89AB_CDEF, 1'b0, 4'b1111, 32'h0,        32'h89AB_CDEF};
    vecs[5]  = '{1'b0, 3'b000, 32'h2000_0003, 32'h0,        32'h7F00_0000, 1'b0, 4'b1000, 32'h0,        32'h0000_007F};
    vecs[6]  = '{1'b1, 3'b001, 32'h3000_0002, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[7]  = '{1'b1, 3'b000, 32'h3000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h3000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h4000_0001, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h4000_0000, 32'h0000_0011, 32'h5555_5555, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'b001, 32'h4000_0003, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'b011, 32'h4000_0000, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 3'b010, 32'h4000_0002, 32'h0BAD_0BAD, 32'h5555_5555, 1'b1, 4'b0000, 32'h0,        32'h0};
    order[0] = 2'b01; order[1] = 2'b01; order[2] = 2'b10;
    order[3] = 2'b01; order[4] = 2'b01; order[5] = 2'b10;

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0;
    ls_len = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("reset_outputs", |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                           mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_after_reset", {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid}, 64'd0);

    // Fetch only.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0104; mem_ready = 1'b1; mem_rdata = 32'h0051_0093;
    #1;
    chk("fetch_gnt", {if_gnt, ls_gnt}, 64'b10);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("fetch_memreq", {mem_req, mem_we, mem_be}, 64'b10_1111);
    chk("fetch_addr", mem_addr, 64'h104);
    @(posedge clk); #1;
    chk("fetch_rvalid", {if_rvalid, ls_rvalid, mem_req}, 64'b100);
    chk("fetch_rdata", if_rdata, 64'h0051_0093);
    @(posedge clk); #1;
    chk("fetch_done", if_rvalid, 64'd0);

    for (int i = 0; i < 14; i++) run_ls(vecs[i], i);

    // Starvation: both requesters held high continuously.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0200;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'b010; ls_addr = 32'h0000_0300;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    #1;
    for (int g = 0; g < 6; g++) begin
      got = 2'b00;
      for (int c = 0; c < 20 && got == 2'b00; c++) begin
        if (if_gnt || ls_gnt) begin
          got = {if_gnt, ls_gnt};
        end else begin
          @(negedge clk); #1;
        end
      end
      chk($sformatf("starve_order%0d", g), got, {62'd0, order[g]});
      @(negedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Wait states: SW with mem_ready low for three edges.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_len = 3'b010; ls_addr = 32'h0000_0108;
    ls_wdata = 32'hCAFE_F00D; mem_ready = 1'b0;
    #1;
    chk("ws_gnt", ls_gnt, 64'd1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("ws_hold%0d", w), {mem_req, mem_we, mem_be, ls_rvalid}, 64'b1_1_1111_0);
      chk($sformatf("ws_fields%0d", w), {mem_addr, mem_wdata}, {32'h0000_0108, 32'hCAFE_F00D});
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    chk("ws_still_busy", {mem_req, ls_rvalid}, 64'b10);
    @(posedge clk); #1;
    chk("ws_resp", {mem_req, ls_rvalid, ls_err}, 64'b010);
    chk("ws_resp_rdata", ls_rdata, 64'd0);
    @(posedge clk); #1;

    // Reset dropped mid-BUSY.
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'b010; ls_addr = 32'h0000_0040; mem_ready = 1'b0;
    #1;
    chk("rst_gnt", ls_gnt, 64'd1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    chk("rst_busy", mem_req, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                               mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_no_rvalid%0d", r), {ls_rvalid, if_rvalid, mem_req}, 64'd0);
    end
    run_ls(vecs[0], 100);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the load/store path, which is driven by the decoder's mem_read, mem_write and mem_op_length (funct3) outputs.
- Arbitrates between the two requesters, sequences each access through a small FSM and generates byte enables and store-lane alignment.
- Extracts and sign/zero-extends load data and reports misaligned or illegal accesses without touching memory.
- Sits between the fetch/LSU stages and the memory model.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced a grant (legal range 1..15)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  32  fetch byte address (word aligned by fetch; bits[1:0] ignored)
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  32  fetched word
ls_req  input  1  load/store request; fields held until ls_gnt
ls_we  input  1  1=store (decoder mem_write), 0=load
ls_len  input  3  funct3 access type (decoder mem_op_length)
ls_addr  input  32  byte address (ALU result)
ls_wdata  input  32  store data (rs2), low bits significant
ls_gnt  output  1  LSU request accepted this cycle
ls_rvalid  output  1  one-cycle completion pulse (loads and stores)
ls_rdata  output  32  extended load data; 0 for stores and errors
ls_err  output  1  qualifies ls_rvalid: misaligned/illegal access
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write strobe
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned store data
mem_ready  input  1  memory completes the request in this cycle
mem_rdata  input  32  read data, valid when mem_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE, starve counter 0, every output 0, including mem_req (dropped immediately mid-transaction). The in-flight access is abandoned with no rvalid.
- FSM states IDLE, BUSY, RESP, ERR.
- IDLE: if any req is present, exactly one gnt is driven combinationally in that cycle.
  - Priority: ls wins, unless if_req is present and the starve counter == STARVE_LIMIT, in which case fetch wins.
  - At that edge the transaction (owner, we, len, addr, wdata) is registered.
  - Next state is ERR if the access is illegal, else BUSY.
- Starve counter:
  - Increments on an ls grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, or on an ls grant with if_req=0.
- BUSY: mem_req=1 with registered mem_we/mem_addr/mem_be/mem_wdata held stable.
  - On an edge with mem_ready=1: load data is latched, then RESP.
  - No gnt is issued while BUSY, RESP or ERR.
- RESP: a one-cycle rvalid pulse to the owner, data valid; then IDLE.
- ERR: ls_rvalid=1, ls_err=1, ls_rdata=0 for one cycle; mem_req stays 0; then IDLE.
- Latency: req at cycle 0 with mem_ready tied 1 → mem_req in cycle 1, rvalid in cycle 2. Each extra wait cycle adds 1. The next grant comes no earlier than the cycle after RESP.
- ls_len decoding (lane = addr[1:0]):
  - 000 LB/SB: be = 0001<<lane.
  - 001 LH/SH: be = 0011<<lane; illegal if addr[0]=1.
  - 010 LW/SW: be = 1111; illegal if lane≠0.
  - 100 LBU, 101 LHU: loads only, same alignment rules as LB/LH.
  - All other codes are illegal, and 100/101 are illegal with we=1.
- Store data: byte replicated to all 4 lanes, halfword replicated to both halves, word as-is.
- Load data: selected lane(s) of mem_rdata. Sign-extend for 000/001, zero-extend for 100/101.
- Fetch: always be=1111, we=0, no error check.
- rvalid outputs are 0 outside RESP/ERR; data outputs hold their last value, except ls_rdata, which is forced 0 on store/ERR completions.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0104, mem_ready=1, mem_rdata=0x0051_0093 → if_gnt cycle 0; mem_req, mem_addr=0x104, be=1111 in cycle 1; if_rvalid, if_rdata=0x0051_0093 in cycle 2.
- LB sign-extension: ls_len=000, addr=0x...0002, mem_rdata=0x1280_FF34 → be=0100, ls_rdata=0xFFFF_FF80. LBU on the same data → 0x0000_0080. LHU at addr 0x...2 → 0x0000_1280.
- SH store: addr=0x...0002, ls_wdata=0xDEAD_BEEF → mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF. ls_rvalid pulses with ls_rdata=0.
- Illegal access: LW at addr 0x...0001, and SB with ls_len=100 → mem_req never asserted; ls_rvalid=ls_err=1 one cycle after gnt.
- Starvation: if_req and ls_req held high continuously, STARVE_LIMIT=2 → grant order ls, ls, if, ls, ls, if.
- Wait states plus reset: mem_ready low 3 cycles → mem_req and fields stable throughout. Drop rst_n mid-BUSY → all outputs 0 asynchronously, no rvalid after release; the next request proceeds normally.
